// File: rtl/woodpecker_inputs.sv
// Woodpecker control-input front end: PS/2 key and joystick decode, Horz direction remap,
// coin pulse generation with lockout, and the active-low in0/in1 ports for the pacman core.
module woodpecker_inputs #(
  parameter int unsigned COIN_LEN = 32'd600000,
  parameter int unsigned COIN_GAP = 32'd600000,
  parameter int unsigned CW       = 32'd20
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ENA_6,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  input  logic        rotate,
  output logic [7:0]  in0,
  output logic [7:0]  in1
);

  localparam logic [CW-1:0] LEN_LD   = CW'(COIN_LEN - 32'd1);
  localparam logic [CW-1:0] GAP_LD   = CW'(COIN_GAP - 32'd1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  localparam int unsigned K_UP1    = 32'd0;
  localparam int unsigned K_DOWN1  = 32'd1;
  localparam int unsigned K_LEFT1  = 32'd2;
  localparam int unsigned K_RIGHT1 = 32'd3;
  localparam int unsigned K_FIRE1  = 32'd4;
  localparam int unsigned K_START1 = 32'd5;
  localparam int unsigned K_START2 = 32'd6;
  localparam int unsigned K_SKIP1  = 32'd7;
  localparam int unsigned K_COIN1  = 32'd8;
  localparam int unsigned K_COIN2  = 32'd9;
  localparam int unsigned K_UP2    = 32'd10;
  localparam int unsigned K_DOWN2  = 32'd11;
  localparam int unsigned K_LEFT2  = 32'd12;
  localparam int unsigned K_RIGHT2 = 32'd13;
  localparam int unsigned K_FIRE2  = 32'd14;
  localparam int unsigned K_SKIP2  = 32'd15;

  typedef enum logic [1:0] {
    C_IDLE  = 2'd0,
    C_PULSE = 2'd1,
    C_GAP   = 2'd2
  } coin_state_t;

  logic        tog_prev_r;
  logic        primed_r;
  logic        key_evt_s;
  logic [15:0] keys_r;
  logic [15:0] keys_nxt_s;
  logic [7:0]  joy0_r;
  logic [7:0]  joy1_r;
  logic        rot_r;

  logic u1_s, d1_s, l1_s, r1_s, u2_s, d2_s, l2_s, r2_s;
  logic up1_s, down1_s, left1_s, right1_s, up2_s, down2_s, left2_s, right2_s;
  logic fire1_s, fire2_s, start1_s, start2_s, skip1_s, skip2_s;
  logic [1:0] coin_req_s;
  logic [1:0] coin_s;
  logic       unused_s;

  // The first cycle after reset only primes tog_prev, so a stale toggle is never taken as an event.
  assign key_evt_s = primed_r & (ps2_key[10] ^ tog_prev_r);

  // Key decode: arrows match with or without the E0 prefix, every other key only without it.
  always_comb begin
    keys_nxt_s = keys_r;
    if (key_evt_s) begin
      case (ps2_key[8:0])
        9'h075, 9'h175: keys_nxt_s[K_UP1]    = ps2_key[9];
        9'h072, 9'h172: keys_nxt_s[K_DOWN1]  = ps2_key[9];
        9'h06B, 9'h16B: keys_nxt_s[K_LEFT1]  = ps2_key[9];
        9'h074, 9'h174: keys_nxt_s[K_RIGHT1] = ps2_key[9];
        9'h029, 9'h014: keys_nxt_s[K_FIRE1]  = ps2_key[9];
        9'h005, 9'h016: keys_nxt_s[K_START1] = ps2_key[9];
        9'h006, 9'h01E: keys_nxt_s[K_START2] = ps2_key[9];
        9'h003:         keys_nxt_s[K_SKIP1]  = ps2_key[9];
        9'h02E:         keys_nxt_s[K_COIN1]  = ps2_key[9];
        9'h036:         keys_nxt_s[K_COIN2]  = ps2_key[9];
        9'h02D:         keys_nxt_s[K_UP2]    = ps2_key[9];
        9'h02B:         keys_nxt_s[K_DOWN2]  = ps2_key[9];
        9'h023:         keys_nxt_s[K_LEFT2]  = ps2_key[9];
        9'h034:         keys_nxt_s[K_RIGHT2] = ps2_key[9];
        9'h01C:         keys_nxt_s[K_FIRE2]  = ps2_key[9];
        9'h01B:         keys_nxt_s[K_SKIP2]  = ps2_key[9];
        default:        keys_nxt_s = keys_r;
      endcase
    end else begin
      keys_nxt_s = keys_r;
    end
  end

  // Key flags, toggle tracking and the joystick/rotate sample that lines up with the key path.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      tog_prev_r <= 1'b0;
      primed_r   <= 1'b0;
      keys_r     <= 16'h0000;
      joy0_r     <= 8'h00;
      joy1_r     <= 8'h00;
      rot_r      <= 1'b0;
    end else begin
      tog_prev_r <= ps2_key[10];
      primed_r   <= 1'b1;
      keys_r     <= keys_nxt_s;
      joy0_r     <= joystick_0[7:0];
      joy1_r     <= joystick_1[7:0];
      rot_r      <= rotate;
    end
  end

  assign r1_s = keys_r[K_RIGHT1] | joy0_r[0];
  assign l1_s = keys_r[K_LEFT1]  | joy0_r[1];
  assign d1_s = keys_r[K_DOWN1]  | joy0_r[2];
  assign u1_s = keys_r[K_UP1]    | joy0_r[3];
  assign r2_s = keys_r[K_RIGHT2] | joy1_r[0];
  assign l2_s = keys_r[K_LEFT2]  | joy1_r[1];
  assign d2_s = keys_r[K_DOWN2]  | joy1_r[2];
  assign u2_s = keys_r[K_UP2]    | joy1_r[3];

  // Horz orientation turns the panel a quarter turn: each direction takes its neighbour's input.
  assign up1_s    = rot_r ? l1_s : u1_s;
  assign down1_s  = rot_r ? r1_s : d1_s;
  assign left1_s  = rot_r ? d1_s : l1_s;
  assign right1_s = rot_r ? u1_s : r1_s;
  assign up2_s    = rot_r ? l2_s : u2_s;
  assign down2_s  = rot_r ? r2_s : d2_s;
  assign left2_s  = rot_r ? d2_s : l2_s;
  assign right2_s = rot_r ? u2_s : r2_s;

  assign fire1_s  = keys_r[K_FIRE1]  | joy0_r[4];
  assign fire2_s  = keys_r[K_FIRE2]  | joy1_r[4];
  assign start1_s = keys_r[K_START1] | joy0_r[5] | joy1_r[5];
  assign start2_s = keys_r[K_START2] | joy0_r[6] | joy1_r[6];
  assign skip1_s  = keys_r[K_SKIP1]  | joy0_r[7];
  assign skip2_s  = keys_r[K_SKIP2]  | joy1_r[7];

  assign unused_s = &{1'b0, joystick_0[15:9], joystick_1[15:9], skip2_s};

  assign coin_req_s = {keys_r[K_COIN2] | joystick_1[8], keys_r[K_COIN1] | joystick_0[8]};

  for (genvar ch = 0; ch < 2; ch++) begin : g_coin
    coin_state_t   state_r;
    coin_state_t   state_nxt_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic          req_prev_r;

    // Coin pulse FSM: edges arriving during PULSE or GAP are dropped, not queued.
    always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      case (state_r)
        C_IDLE: begin
          if (coin_req_s[ch] && !req_prev_r) begin
            state_nxt_s = C_PULSE;
            cnt_nxt_s   = LEN_LD;
          end else begin
            state_nxt_s = C_IDLE;
            cnt_nxt_s   = cnt_r;
          end
        end
        C_PULSE: begin
          if (ENA_6 && (cnt_r == CNT_ZERO)) begin
            state_nxt_s = C_GAP;
            cnt_nxt_s   = GAP_LD;
          end else if (ENA_6) begin
            state_nxt_s = C_PULSE;
            cnt_nxt_s   = cnt_r - CNT_ONE;
          end else begin
            state_nxt_s = C_PULSE;
            cnt_nxt_s   = cnt_r;
          end
        end
        C_GAP: begin
          if (ENA_6 && (cnt_r == CNT_ZERO)) begin
            state_nxt_s = C_IDLE;
            cnt_nxt_s   = CNT_ZERO;
          end else if (ENA_6) begin
            state_nxt_s = C_GAP;
            cnt_nxt_s   = cnt_r - CNT_ONE;
          end else begin
            state_nxt_s = C_GAP;
            cnt_nxt_s   = cnt_r;
          end
        end
        default: begin
          state_nxt_s = C_IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end
      endcase
    end

    // Coin FSM state, counter and request history.
    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        state_r    <= C_IDLE;
        cnt_r      <= CNT_ZERO;
        req_prev_r <= 1'b0;
      end else begin
        state_r    <= state_nxt_s;
        cnt_r      <= cnt_nxt_s;
        req_prev_r <= coin_req_s[ch];
      end
    end

    assign coin_s[ch] = (state_r == C_PULSE);
  end

  // Active-low output ports; reset forces every button released at once.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      in0 <= 8'hFF;
      in1 <= 8'hFF;
    end else begin
      in0 <= ~{1'b0, coin_s[1], coin_s[0], skip1_s, down1_s, right1_s, left1_s, up1_s};
      in1 <= ~{fire2_s, start2_s, start1_s, fire1_s, down2_s, right2_s, left2_s, up2_s};
    end
  end

endmodule
